// File: rtl/usb_uart_line_buffer.sv
// rtl/usb_uart_line_buffer.sv - byte FIFO between usb_uart receive and transmit ports with optional line release
module usb_uart_line_buffer #(
    parameter int DEPTH         = 64,
    parameter bit LINE_MODE     = 1'b1,
    parameter int FLUSH_TIMEOUT = 48000
) (
    input  logic                     clk_48mhz,
    input  logic                     reset,
    input  logic [7:0]               in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [7:0]               out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(FLUSH_TIMEOUT + 1);
    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);
    localparam logic [TW-1:0] IDLE_LIMIT = TW'(FLUSH_TIMEOUT);

    logic [7:0]    mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW:0]   rel_ptr;
    logic [AW:0]   mem_count;
    logic [TW-1:0] idle_cnt;
    logic          full;
    logic          wr_en;
    logic          rd_en;
    logic          out_xfer;
    logic          is_term;
    logic          timeout;

    assign mem_count = wr_ptr - rd_ptr;
    assign full      = (mem_count == FULL_COUNT);
    assign in_ready  = !full && !reset;
    assign wr_en     = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;
    // Only released bytes (rd_ptr .. rel_ptr) may move into the output register.
    assign rd_en     = (!out_valid || out_ready) && (rd_ptr != rel_ptr);
    assign is_term   = (in_data == 8'h0D) || (in_data == 8'h0A);
    assign timeout   = (idle_cnt == IDLE_LIMIT) && (rel_ptr != wr_ptr);

    always_ff @(posedge clk_48mhz) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= in_data;
        end
    end

    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            rel_ptr   <= '0;
            idle_cnt  <= '0;
            level     <= '0;
            out_valid <= 1'b0;
            out_data  <= 8'h00;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end

            if (rd_en) begin
                rd_ptr    <= rd_ptr + 1'b1;
                out_data  <= mem[rd_ptr[AW-1:0]];
                out_valid <= 1'b1;
            end else if (out_xfer) begin
                out_valid <= 1'b0;
            end

            case ({wr_en, out_xfer})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase

            // Terminator wins over full/timeout; it releases the terminator byte itself.
            if (LINE_MODE == 1'b0) begin
                rel_ptr <= wr_ptr;
            end else if (wr_en && is_term) begin
                rel_ptr <= wr_ptr + 1'b1;
            end else if (full || timeout) begin
                rel_ptr <= wr_ptr;
            end

            if (wr_en || (rel_ptr == wr_ptr)) begin
                idle_cnt <= '0;
            end else if (idle_cnt != IDLE_LIMIT) begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_usb_uart_line_buffer.sv
// tb/tb_usb_uart_line_buffer.sv - self-checking bench for usb_uart_line_buffer
module tb_usb_uart_line_buffer;

    localparam int DEPTH = 64;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk_48mhz = 1'b0;
    logic          reset;

    logic [7:0]    s_in_data, s_out_data, l_in_data, l_out_data;
    logic          s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic          l_in_valid, l_in_ready, l_out_valid, l_out_ready;
    logic [LW-1:0] s_level, l_level;

    int checks   = 0;
    int failures = 0;

    always #5 clk_48mhz = ~clk_48mhz;

    usb_uart_line_buffer #(.DEPTH(DEPTH), .LINE_MODE(1'b0), .FLUSH_TIMEOUT(16)) u_stream (
        .clk_48mhz (clk_48mhz),
        .reset     (reset),
        .in_data   (s_in_data),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .out_data  (s_out_data),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .level     (s_level)
    );

    usb_uart_line_buffer #(.DEPTH(DEPTH), .LINE_MODE(1'b1), .FLUSH_TIMEOUT(16)) u_line (
        .clk_48mhz (clk_48mhz),
        .reset     (reset),
        .in_data   (l_in_data),
        .in_valid  (l_in_valid),
        .in_ready  (l_in_ready),
        .out_data  (l_out_data),
        .out_valid (l_out_valid),
        .out_ready (l_out_ready),
        .level     (l_level)
    );

    typedef struct {
        logic       iv;
        logic [7:0] d;
        logic       ordy;
        logic       e_ir;
        logic       e_ov;
        logic [7:0] e_od;
        int         e_lvl;
    } vec_t;

    vec_t vt[14];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_48mhz);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] seq [200];
        int         idx;
        int         acc;
        int         sent;
        int         rcvd;
        int         seen;
        logic       found;
        logic       ir_before;
        logic       prev_stall;
        logic [7:0] prev_data;

        // Stream-mode per-cycle vectors: {iv, d, out_ready, in_ready, out_valid, out_data, level}
        vt[0]  = '{1'b1, 8'h41, 1'b1, 1'b1, 1'b0, 8'h00, 1};
        vt[1]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1};
        vt[2]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h41, 1};
        vt[3]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 0};
        vt[4]  = '{1'b1, 8'h10, 1'b1, 1'b1, 1'b0, 8'h00, 1};
        vt[5]  = '{1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 8'h00, 2};
        vt[6]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h10, 2};
        vt[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h11, 1};
        vt[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 0};
        vt[9]  = '{1'b1, 8'h20, 1'b0, 1'b1, 1'b0, 8'h00, 1};
        vt[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1};
        vt[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h20, 1};
        vt[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h20, 1};
        vt[13] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 0};

        for (int i = 0; i < 200; i++) seq[i] = 8'($urandom);

        reset       = 1'b1;
        s_in_data   = 8'h00; s_in_valid = 1'b0; s_out_ready = 1'b0;
        l_in_data   = 8'h00; l_in_valid = 1'b0; l_out_ready = 1'b0;
        #1;
        check("rst_s_in_ready", int'(s_in_ready), 0);
        check("rst_l_in_ready", int'(l_in_ready), 0);
        step();
        step();
        check("rst_s_out_valid", int'(s_out_valid), 0);
        check("rst_s_level", int'(s_level), 0);
        check("rst_s_out_data", int'(s_out_data), 0);
        check("rst_l_out_valid", int'(l_out_valid), 0);
        check("rst_l_level", int'(l_level), 0);
        reset = 1'b0;
        #1;
        check("post_rst_s_in_ready", int'(s_in_ready), 1);
        check("post_rst_l_in_ready", int'(l_in_ready), 1);

        // Stream latency, back-to-back and held-output vectors
        for (int i = 0; i < 14; i++) begin
            s_in_valid  = vt[i].iv;
            s_in_data   = vt[i].d;
            s_out_ready = vt[i].ordy;
            step();
            check($sformatf("vec%0d_in_ready", i), int'(s_in_ready), int'(vt[i].e_ir));
            check($sformatf("vec%0d_out_valid", i), int'(s_out_valid), int'(vt[i].e_ov));
            if (vt[i].e_ov) check($sformatf("vec%0d_out_data", i), int'(s_out_data), int'(vt[i].e_od));
            check($sformatf("vec%0d_level", i), int'(s_level), vt[i].e_lvl);
        end
        s_in_valid = 1'b0;

        // Line mode: hold until terminator, then burst
        l_out_ready = 1'b1;
        l_in_valid = 1'b1; l_in_data = 8'h41; step();
        check("t2_hold_a", int'(l_out_valid), 0);
        l_in_data = 8'h42; step();
        check("t2_hold_b", int'(l_out_valid), 0);
        l_in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t2_hold_idle", int'(l_out_valid), 0);
        end
        l_in_valid = 1'b1; l_in_data = 8'h0D; step();
        l_in_valid = 1'b0;
        check("t2_level3", int'(l_level), 3);
        check("t2_hold_cr", int'(l_out_valid), 0);
        step();
        check("t2_ov1", int'(l_out_valid), 1);
        check("t2_d41", int'(l_out_data), 'h41);
        check("t2_level_pre", int'(l_level), 3);
        step();
        check("t2_ov2", int'(l_out_valid), 1);
        check("t2_d42", int'(l_out_data), 'h42);
        step();
        check("t2_ov3", int'(l_out_valid), 1);
        check("t2_d0d", int'(l_out_data), 'h0D);
        step();
        check("t2_done_ov", int'(l_out_valid), 0);
        check("t2_done_level", int'(l_level), 0);

        // Line mode idle timeout
        l_in_valid = 1'b1; l_in_data = 8'h78; step();
        l_in_data = 8'h79; step();
        l_in_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (l_out_valid) seen++;
        end
        check("t5_quiet", seen, 0);
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            step();
            found = l_out_valid;
        end
        check("t5_released", int'(found), 1);
        check("t5_d78", int'(l_out_data), 'h78);
        step();
        check("t5_ov79", int'(l_out_valid), 1);
        check("t5_d79", int'(l_out_data), 'h79);
        step();
        check("t5_done", int'(l_out_valid), 0);

        // Line mode forced release on full
        l_out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 64; i++) begin
            l_in_valid = 1'b1;
            l_in_data  = 8'(8'h80 + i);
            if (l_in_ready) acc++;
            step();
        end
        l_in_valid = 1'b0;
        check("t4_accepted", acc, 64);
        check("t4_full_in_ready", int'(l_in_ready), 0);
        check("t4_level64", int'(l_level), 64);
        check("t4_no_out_yet", int'(l_out_valid), 0);
        found = 1'b0;
        ir_before = 1'b1;
        for (int i = 0; i < 8 && !found; i++) begin
            ir_before = l_in_ready;
            step();
            found = l_out_valid;
        end
        check("t4_released", int'(found), 1);
        check("t4_throttle", int'(ir_before), 0);
        check("t4_first", int'(l_out_data), 'h80);
        check("t4_level_at_release", int'(l_level), 64);
        l_out_ready = 1'b1;
        idx = 0;
        for (int c = 0; c < 300 && idx < 64; c++) begin
            if (l_out_valid) begin
                check("t4_order", int'(l_out_data), 'h80 + idx);
                idx++;
            end
            step();
        end
        check("t4_drained", idx, 64);
        check("t4_end_level", int'(l_level), 0);
        check("t4_end_in_ready", int'(l_in_ready), 1);

        // Stream fill with out_ready low: memory plus output register
        s_out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 70; c++) begin
            s_in_valid = 1'b1;
            s_in_data  = acc[7:0];
            if (s_in_ready) acc++;
            step();
        end
        s_in_valid = 1'b0;
        check("t3_accepted", acc, 65);
        check("t3_level", int'(s_level), 65);
        check("t3_in_ready_low", int'(s_in_ready), 0);
        s_out_ready = 1'b1;
        idx = 0;
        for (int c = 0; c < 300 && idx < 65; c++) begin
            if (s_out_valid) begin
                check("t3_order", int'(s_out_data), idx);
                idx++;
            end
            step();
        end
        check("t3_drained", idx, 65);
        check("t3_in_ready_high", int'(s_in_ready), 1);
        check("t3_end_level", int'(s_level), 0);

        // Random backpressure over 200 bytes
        sent = 0; rcvd = 0; prev_stall = 1'b0; prev_data = 8'h00;
        for (int c = 0; c < 4000 && rcvd < 200; c++) begin
            s_in_valid  = (sent < 200) && ($urandom_range(0, 3) != 0);
            s_in_data   = seq[(sent < 200) ? sent : 0];
            s_out_ready = 1'($urandom_range(0, 1));
            if (prev_stall) begin
                check("t6_hold_valid", int'(s_out_valid), 1);
                check("t6_hold_data", int'(s_out_data), int'(prev_data));
            end
            if (s_in_valid && s_in_ready) sent++;
            if (s_out_valid && s_out_ready) begin
                check("t6_data", int'(s_out_data), int'(seq[rcvd]));
                rcvd++;
            end
            prev_stall = s_out_valid && !s_out_ready;
            prev_data  = s_out_data;
            step();
        end
        s_in_valid = 1'b0;
        check("t6_received", rcvd, 200);

        // Reset in the middle of a drain
        s_out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            s_in_valid = 1'b1;
            s_in_data  = 8'(8'hA0 + i);
            step();
        end
        s_in_valid  = 1'b0;
        s_out_ready = 1'b1;
        step();
        step();
        check("t6r_mid_drain", int'(s_out_valid), 1);
        reset = 1'b1;
        #1;
        check("t6r_in_ready_in_reset", int'(s_in_ready), 0);
        step();
        check("t6r_out_valid", int'(s_out_valid), 0);
        check("t6r_level", int'(s_level), 0);
        reset = 1'b0;
        #1;
        check("t6r_in_ready_after", int'(s_in_ready), 1);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (s_out_valid) seen++;
        end
        check("t6r_no_old_bytes", seen, 0);
        s_in_valid = 1'b1; s_in_data = 8'h55; step();
        s_in_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            step();
            found = s_out_valid;
        end
        check("t6r_new_byte_seen", int'(found), 1);
        check("t6r_new_byte", int'(s_out_data), 'h55);
        step();
        check("t6r_end_ov", int'(s_out_valid), 0);
        check("t6r_end_level", int'(s_level), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
